// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a batch of N_OPS operands into an 8-bit accumulator with sticky carry/overflow and a done/ack handshake
module sum_accumulator #(
  parameter int N_OPS = 4
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic [7:0] X,
  input  logic       dav_,
  output logic       rfd,
  output logic [7:0] S,
  output logic       c_out,
  output logic       ow,
  output logic       done,
  input  logic       ack
);
  typedef enum logic [1:0] {S_IDLE, S_WAITH, S_DONE, S_ACKL} state_t;
  localparam logic [7:0] N_LAST = 8'(N_OPS);
  state_t state, state_n;
  logic [7:0] acc, acc_n, cnt, cnt_n;
  logic       c, c_n, ov, ov_n, rfd_n, done_n;
  logic [8:0] sum;
  assign sum   = {1'b0, acc} + {1'b0, X};
  assign S     = acc;
  assign c_out = c;
  assign ow    = ov;
  // handshake sequencing and per-step accumulation
  always_comb begin
    state_n = state;
    acc_n   = acc;
    c_n     = c;
    ov_n    = ov;
    cnt_n   = cnt;
    rfd_n   = rfd;
    done_n  = done;
    case (state)
      S_IDLE: if (!dav_) begin
        acc_n   = sum[7:0];
        c_n     = c | sum[8];
        ov_n    = ov | ((acc[7] == X[7]) & (sum[7] != acc[7]));
        cnt_n   = cnt + 8'd1;
        rfd_n   = 1'b0;
        state_n = S_WAITH;
      end
      S_WAITH: if (dav_) begin
        done_n  = cnt == N_LAST;
        rfd_n   = cnt != N_LAST;
        state_n = cnt == N_LAST ? S_DONE : S_IDLE;
      end
      S_DONE: if (ack) begin
        done_n  = 1'b0;
        acc_n   = '0;
        c_n     = 1'b0;
        ov_n    = 1'b0;
        cnt_n   = '0;
        state_n = S_ACKL;
      end
      S_ACKL: if (!ack) begin
        rfd_n   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
      acc   <= '0;
      c     <= 1'b0;
      ov    <= 1'b0;
      cnt   <= '0;
      rfd   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      c     <= c_n;
      ov    <= ov_n;
      cnt   <= cnt_n;
      rfd   <= rfd_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: randomized and directed checks of sum_accumulator against an arithmetic batch model
module tb_sum_accumulator;
  typedef logic [7:0] ops_t[$];
  logic       clock = 1'b0;
  logic       reset_, dav_, rfd, c_out, ow, done, ack;
  logic [7:0] X, S;
  int checks = 0;
  int failures = 0;

  sum_accumulator #(.N_OPS(4)) dut (
    .clock(clock), .reset_(reset_), .X(X), .dav_(dav_), .rfd(rfd),
    .S(S), .c_out(c_out), .ow(ow), .done(done), .ack(ack)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Integer-arithmetic model of a whole batch: returns {sum mod 256, any carry, any signed overflow}
  function automatic logic [9:0] model(input ops_t ops);
    int a = 0;
    int t, sa, sx;
    logic cy = 1'b0, of = 1'b0;
    foreach (ops[i]) begin
      t  = a + int'(ops[i]);
      sa = a > 127 ? a - 256 : a;
      sx = int'(ops[i]) > 127 ? int'(ops[i]) - 256 : int'(ops[i]);
      if (t > 255) cy = 1'b1;
      if (sa + sx > 127 || sa + sx < -128) of = 1'b1;
      a = t % 256;
    end
    return {a[7:0], cy, of};
  endfunction

  task automatic send_op(input logic [7:0] x, input int hold);
    @(negedge clock);
    X = x;
    dav_ = 1'b0;
    repeat (hold + 1) @(negedge clock);
    dav_ = 1'b1;
    X = 8'($urandom);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_ = 1'b0; dav_ = 1'b1; ack = 1'b0; X = 8'h00;
    repeat (2) @(negedge clock);
    checks++;
    if ({S, c_out, ow, rfd, done} !== {8'h00, 4'b0010}) begin
      failures++;
      $display("FAIL reset: S=%h c=%b ow=%b rfd=%b done=%b expected S=00 c=0 ow=0 rfd=1 done=0", S, c_out, ow, rfd, done);
    end
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_batch(input string name, input ops_t ops, input int max_hold, input int ack_hold);
    logic [9:0] m;
    logic [7:0] partial;
    ops_t pre;
    m = model(ops);
    foreach (ops[i]) begin
      send_op(ops[i], max_hold == 0 ? 0 : int'($urandom_range(max_hold, 0)));
      pre.push_back(ops[i]);
      partial = model(pre) >> 2;
      if (i < ops.size() - 1) begin
        checks++;
        if ({S, rfd, done} !== {partial, 2'b10}) begin
          failures++;
          $display("FAIL %s step%0d: S=%h rfd=%b done=%b expected S=%h rfd=1 done=0", name, i, S, rfd, done, partial);
        end
      end
    end
    checks++;
    if ({S, c_out, ow, done, rfd} !== {m, 2'b10}) begin
      failures++;
      $display("FAIL %s result: S=%h c=%b ow=%b done=%b rfd=%b expected S=%h c=%b ow=%b done=1 rfd=0",
               name, S, c_out, ow, done, rfd, m[9:2], m[1], m[0]);
    end
    X = 8'($urandom);
    dav_ = 1'b0;
    @(negedge clock);
    checks++;
    if ({S, c_out, ow, done, rfd} !== {m, 2'b10}) begin
      failures++;
      $display("FAIL %s frozen: S=%h c=%b ow=%b done=%b rfd=%b expected S=%h c=%b ow=%b done=1 rfd=0",
               name, S, c_out, ow, done, rfd, m[9:2], m[1], m[0]);
    end
    dav_ = 1'b1;
    ack = 1'b1;
    for (int k = 0; k < ack_hold; k++) begin
      @(negedge clock);
      dav_ = 1'b0;
      X = 8'($urandom);
      checks++;
      if ({S, c_out, ow, done, rfd} !== 12'h000) begin
        failures++;
        $display("FAIL %s ack%0d: S=%h c=%b ow=%b done=%b rfd=%b expected all 0", name, k, S, c_out, ow, done, rfd);
      end
    end
    ack = 1'b0;
    dav_ = 1'b1;
    @(negedge clock);
    checks++;
    if ({S, rfd, done} !== {8'h00, 2'b10}) begin
      failures++;
      $display("FAIL %s ack_release: S=%h rfd=%b done=%b expected S=00 rfd=1 done=0", name, S, rfd, done);
    end
  endtask

  task automatic test_directed();
    test_batch("b_0008", {8'h00, 8'h08, 8'h00, 8'h00}, 0, 1);
    test_batch("b_8080", {8'h80, 8'h80, 8'h00, 8'h00}, 0, 1);
    test_batch("b_4040", {8'h40, 8'h40, 8'h00, 8'h00}, 0, 1);
  endtask

  task automatic test_hold_low();
    @(negedge clock);
    X = 8'hFF;
    dav_ = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      X = 8'($urandom_range(255, 1));
      checks++;
      if ({S, rfd, done} !== {8'hFF, 2'b00}) begin
        failures++;
        $display("FAIL hold%0d: S=%h rfd=%b done=%b expected S=ff rfd=0 done=0", k, S, rfd, done);
      end
      @(negedge clock);
    end
    dav_ = 1'b1;
    @(negedge clock);
    checks++;
    if ({S, rfd} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL hold_release: S=%h rfd=%b expected S=ff rfd=1", S, rfd);
    end
    for (int k = 0; k < 2; k++) send_op(8'h01, 0);
    @(negedge clock);
    X = 8'h01;
    dav_ = 1'b0;
    @(negedge clock);
    dav_ = 1'b1;
    @(negedge clock);
    checks++;
    if ({S, c_out, ow, done} !== {8'h02, 3'b101}) begin
      failures++;
      $display("FAIL b_ff01: S=%h c=%b ow=%b done=%b expected S=02 c=1 ow=0 done=1", S, c_out, ow, done);
    end
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ack_hold();
    test_batch("ack_hold3", {8'h7F, 8'h01, 8'h80, 8'h05}, 0, 3);
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b;
    a = 8'($urandom_range(255, 1));
    b = 8'($urandom);
    send_op(a, 0);
    send_op(b, 0);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    checks++;
    if ({S, rfd, done} !== {8'(a + b), 2'b10}) begin
      failures++;
      $display("FAIL ack_in_idle: S=%h rfd=%b done=%b expected S=%h rfd=1 done=0", S, rfd, done, 8'(a + b));
    end
    #2 reset_ = 1'b0;
    #1;
    checks++;
    if ({S, c_out, ow, rfd, done} !== {8'h00, 4'b0010}) begin
      failures++;
      $display("FAIL reset_mid: S=%h c=%b ow=%b rfd=%b done=%b expected S=00 c=0 ow=0 rfd=1 done=0", S, c_out, ow, rfd, done);
    end
    @(negedge clock);
    reset_ = 1'b1;
    test_batch("after_reset", {8'h01, 8'h01, 8'h01, 8'h01}, 0, 1);
  endtask

  task automatic test_random();
    ops_t q;
    for (int n = 0; n < 25; n++) begin
      q = {};
      for (int i = 0; i < 4; i++)
        q.push_back($urandom_range(3, 0) == 0 ? ($urandom_range(1, 0) ? 8'h80 : 8'h7F) : 8'($urandom));
      test_batch($sformatf("rand%0d", n), q, 2, int'($urandom_range(3, 1)));
    end
  endtask

  task automatic test_back_to_back();
    test_batch("b2b_a", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 1);
    test_batch("b2b_b", {8'h81, 8'h81, 8'h7F, 8'h7F}, 0, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_low();
    test_ack_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
